// File: rtl/add_serial_16bit_pkg.sv
// Shared constants and types for the bit-serial add/subtract engine.
package add_serial_16bit_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/add_serial_16bit_if.sv
// Operand/result bundle between the datapath controller and the serial adder.
interface add_serial_16bit_if
    import add_serial_16bit_pkg::*;
#(
    parameter int W = WIDTH
);

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] shuma;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, shuma, cout, zero, neg, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, shuma, cout, zero, neg, ovf
    );

endinterface

// File: rtl/add_serial_16bit_add_1bit.sv
// Single full-adder cell; the serial engine reuses it once per bit.
module add_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic shuma_o,
    output logic cout_o
);

    // Plain full-adder equations.
    always_comb begin
        shuma_o = a_i ^ b_i ^ cin_i;
        cout_o  = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/add_serial_16bit.sv
// Bit-serial WIDTH-bit add/subtract engine: one bit per clock through add_1bit.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result and flags hold the last outcome
// RUN   | shifting one bit per cycle through the full adder
// FIN   | one-cycle done pulse, result/flags already valid
module add_serial_16bit
    import add_serial_16bit_pkg::*;
(
    input logic                 clk_i,
    input logic                 rst_n_i,
    add_serial_16bit_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   shuma_q, shuma_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   result;

    add_1bit u_add_1bit (
        .a_i     (sa_q[0]),
        .b_i     (sb_q[0]),
        .cin_i   (carry_q),
        .shuma_o (fa_sum),
        .cout_o  (fa_cout)
    );

    // The final sum is the accumulator shifted once more with the MSB's sum bit.
    assign result = {fa_sum, acc_q[WIDTH-1:1]};

    // State, datapath and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            shuma_q <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            shuma_q <= shuma_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath decode; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        shuma_d = shuma_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                    sa_d    = bus.a;
                    sb_d    = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                acc_d   = result;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last step.
                    shuma_d = result;
                    cout_d  = fa_cout;
                    zero_d  = (result == '0);
                    neg_d   = fa_sum;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.shuma = shuma_q;
    assign bus.cout  = cout_q;
    assign bus.zero  = zero_q;
    assign bus.neg   = neg_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_add_serial_16bit.sv
// Scoreboard bench for add_serial_16bit: stimulus pushes expectations, a monitor checks each DONE.
module tb_add_serial_16bit;
    import add_serial_16bit_pkg::*;

    typedef struct {
        logic [15:0] shuma;
        logic [3:0]  flags;      // {cout, zero, neg, ovf}
        int          start_cyc;
    } exp_t;

    logic clk_i;
    logic rst_n_i;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    add_serial_16bit_if #(.W(16)) bus ();

    add_serial_16bit dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (bus.done) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding, shuma=%h", bus.shuma);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (bus.shuma !== e.shuma) begin
                    errors++;
                    $display("FAIL shuma: got %h want %h", bus.shuma, e.shuma);
                end
                checks++;
                if ({bus.cout, bus.zero, bus.neg, bus.ovf} !== e.flags) begin
                    errors++;
                    $display("FAIL flags_czNV: got %b want %b",
                             {bus.cout, bus.zero, bus.neg, bus.ovf}, e.flags);
                end
                checks++;
                if (cyc - e.start_cyc != 17) begin
                    errors++;
                    $display("FAIL latency: got %0d want 17", cyc - e.start_cyc);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] exp_s, input logic [3:0] exp_f, input bit expect_done);
        exp_t e;
        @(negedge clk_i);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        if (expect_done) begin
            e.shuma     = exp_s;
            e.flags     = exp_f;
            e.start_cyc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk_i);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles");
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        rst_n_i   = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk_i);
        check_val("rst_shuma", 32'(bus.shuma), 32'h0000);
        check_val("rst_flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf}), 32'b0100);
        check_val("rst_busy_done", 32'({bus.busy, bus.done}), 32'b00);
        rst_n_i = 1'b1;

        // Directed vectors; each starts in the first IDLE cycle after the previous DONE.
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 4'b0000, 1'b1); wait_done();
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1100, 1'b1); wait_done();
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011, 1'b1); wait_done();
        issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0010, 1'b1); wait_done();
        issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1001, 1'b1); wait_done();
        issue(16'h0003, 16'h0003, 1'b1, 16'h0000, 4'b1100, 1'b1); wait_done();
        issue(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0010, 1'b1); wait_done();

        // Second START mid-run must be ignored; outputs hold the previous result during RUN.
        issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 1'b1);
        repeat (4) @(negedge clk_i);
        check_val("midrun_busy", 32'(bus.busy), 32'h1);
        check_val("midrun_hold_shuma", 32'(bus.shuma), 32'hFFFF);
        check_val("midrun_hold_flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf}), 32'b0010);
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.start = 1'b1;
        @(negedge clk_i);
        bus.start = 1'b0;
        wait_done();
        repeat (25) @(negedge clk_i);

        // Reset mid-run: everything back to reset values and no DONE afterwards.
        issue(16'h1234, 16'h1111, 1'b0, 16'h0000, 4'b0000, 1'b0);
        repeat (7) @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check_val("midrst_shuma", 32'(bus.shuma), 32'h0000);
        check_val("midrst_flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf}), 32'b0100);
        check_val("midrst_busy_done", 32'({bus.busy, bus.done}), 32'b00);
        rst_n_i = 1'b1;
        repeat (25) @(negedge clk_i);

        // Normal operation after the aborted run.
        issue(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 4'b0010, 1'b1); wait_done();
        repeat (3) @(negedge clk_i);

        check_val("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
